// File: rtl/regfile_dump_streamer_pkg.sv
// regfile_dump_streamer_pkg: shared FSM encoding and frame constants for the register dump streamer
package regfile_dump_streamer_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SYNC      = 3'd1,
    SELECT    = 3'd2,
    CAPTURE   = 3'd3,
    SEND_IDX  = 3'd4,
    SEND_DATA = 3'd5,
    DONE      = 3'd6
  } dump_state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int BYTES_PER_REG = 4;
  function automatic logic [7:0] idx_byte(input logic [4:0] i);
    return {3'b000, i};
  endfunction
endpackage

// File: rtl/regfile_dump_streamer_shift_reg.sv
// dump_shift_reg: WIDTH-bit load / shift-left-by-8 register exposing its top byte
module dump_shift_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic [7:0]       top
);
  logic [WIDTH-1:0] q;
  always_ff @(posedge clk)
    q <= reset ? '0 : load ? d : shift ? (q << 8) : q;
  assign top = q[WIDTH-1 -: 8];
endmodule

// File: rtl/regfile_dump_streamer.sv
// regfile_dump_streamer: walks the datapath debug port and streams a framed register dump over valid/ready
module regfile_dump_streamer
  import regfile_dump_streamer_pkg::*;
#(
  parameter int         NUM_REGS  = 32,
  parameter int         WIDTH     = 8 * BYTES_PER_REG,
  parameter int         SEL_WIDTH = 5,
  parameter logic [7:0] SYNC_BYTE = regfile_dump_streamer_pkg::SYNC_BYTE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [SEL_WIDTH-1:0] Debug_Source_select,
  input  logic [WIDTH-1:0]     Debug_out,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);
  localparam int NB  = WIDTH / 8;
  localparam int BCW = NB > 1 ? $clog2(NB) : 1;
  dump_state_t          state;
  logic [SEL_WIDTH-1:0] reg_cnt;
  logic [BCW-1:0]       byte_cnt;
  logic [7:0]           top_byte;
  logic                 xfer;
  logic                 last_byte;
  logic                 last_reg;
  logic                 sh_load;
  logic                 sh_shift;
  assign xfer      = tx_valid && tx_ready;
  assign last_byte = byte_cnt == BCW'(NB - 1);
  assign last_reg  = reg_cnt == SEL_WIDTH'(NUM_REGS - 1);
  assign sh_load   = state == CAPTURE;
  assign sh_shift  = xfer && (state == SEND_IDX || state == SEND_DATA);
  dump_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .shift (sh_shift),
    .d     (Debug_out),
    .top   (top_byte)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      Debug_Source_select <= '0;
      tx_data             <= '0;
      tx_valid            <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      reg_cnt             <= '0;
      byte_cnt            <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= SYNC;
          tx_valid <= 1'b1;
          tx_data  <= SYNC_BYTE;
          busy     <= 1'b1;
        end
        SYNC: if (tx_ready) begin
          state               <= SELECT;
          tx_valid            <= 1'b0;
          reg_cnt             <= '0;
          Debug_Source_select <= '0;
        end
        SELECT: state <= CAPTURE;
        CAPTURE: begin
          state    <= SEND_IDX;
          tx_valid <= 1'b1;
          tx_data  <= idx_byte(5'(reg_cnt));
        end
        SEND_IDX: if (tx_ready) begin
          state    <= SEND_DATA;
          byte_cnt <= '0;
          tx_data  <= top_byte;
        end
        SEND_DATA: if (tx_ready) begin
          if (last_byte) begin
            tx_valid <= 1'b0;
            if (last_reg) begin
              state               <= DONE;
              busy                <= 1'b0;
              done                <= 1'b1;
              Debug_Source_select <= '0;
            end else begin
              state               <= SELECT;
              reg_cnt             <= reg_cnt + 1'b1;
              Debug_Source_select <= reg_cnt + 1'b1;
            end
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
            tx_data  <= top_byte;
          end
        end
        DONE: state <= IDLE;
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_dump_streamer.sv
// tb_regfile_dump_streamer: directed self-checking bench for the register dump streamer
module tb_regfile_dump_streamer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic        busy;
  logic        done;
  logic [4:0]  sel;
  logic [31:0] dbg;
  logic [7:0]  tx_data;
  logic [31:0] regs [32];
  logic [7:0]  got [$];
  logic [7:0]  exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int n_done, done_cyc, stab_err;
  always #5 clk = ~clk;
  always_comb dbg = regs[sel];
  regfile_dump_streamer dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .Debug_Source_select (sel),
    .Debug_out           (dbg),
    .tx_data             (tx_data),
    .tx_valid            (tx_valid),
    .tx_ready            (tx_ready),
    .busy                (busy),
    .done                (done)
  );
  function automatic void build_exp();
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(8'(i));
      for (int b = 3; b >= 0; b--) exp_q.push_back(regs[i][8*b +: 8]);
    end
  endfunction
  function automatic int seq_bad(output int first);
    int bad = 0;
    first = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    return bad;
  endfunction
  task automatic collect(input int mode, input int busy_start_at, input int snap_cyc, input int abort_at);
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [7:0] pd = '0;
    bit restarted = 0;
    got.delete();
    n_done = 0;
    done_cyc = 0;
    stab_err = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 3000; c++) begin
      if (pv && !pr && (tx_valid !== 1'b1 || tx_data !== pd)) stab_err++;
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (c == snap_cyc) regs[3] = 32'h0;
      start = busy_start_at >= 0 && !restarted && got.size() == busy_start_at;
      if (start) restarted = 1;
      if (abort_at >= 0 && got.size() == abort_at) return;
      tx_ready = mode == 0 || c % 3 == 0;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      pv = tx_valid;
      pd = tx_data;
      pr = tx_ready;
      if (done_cyc != 0 && c >= done_cyc + 4) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", tx_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b exp=0", done); end
    n_cmp++; if (sel !== 5'd0) begin n_err++; $display("FAIL rst_sel got=%0d exp=0", sel); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_data got=%h exp=00", tx_data); end
  endtask
  task automatic test_basic();
    int first, bad;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
    build_exp();
    collect(0, -1, -1, -1);
    n_cmp++; if (got.size() != 161) begin n_err++; $display("FAIL basic_len got=%0d exp=161", got.size()); end
    n_cmp++; if (got.size() < 1 || got[0] !== 8'hA5) begin n_err++; $display("FAIL basic_sync got=%h exp=a5", got.size() ? got[0] : 8'hxx); end
    n_cmp++; if (got.size() < 31 || {got[26], got[27], got[28], got[29], got[30]} !== 40'h05_10_00_00_05)
      begin n_err++; $display("FAIL basic_reg5 got=%h exp=0510000005", got.size() >= 31 ? {got[26], got[27], got[28], got[29], got[30]} : 40'hx); end
    bad = seq_bad(first);
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL basic_seq got=%0d bad bytes exp=0 (first at %0d)", bad, first); end
    n_cmp++; if (done_cyc != 226) begin n_err++; $display("FAIL basic_done_cycle got=%0d exp=226", done_cyc); end
    n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL basic_done_count got=%0d exp=1", n_done); end
  endtask
  task automatic test_backpressure();
    int first, bad;
    collect(1, -1, -1, -1);
    n_cmp++; if (stab_err != 0) begin n_err++; $display("FAIL bp_stable got=%0d violations exp=0", stab_err); end
    n_cmp++; if (got.size() != 161) begin n_err++; $display("FAIL bp_len got=%0d exp=161", got.size()); end
    bad = seq_bad(first);
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL bp_seq got=%0d bad bytes exp=0 (first at %0d)", bad, first); end
    n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL bp_done_count got=%0d exp=1", n_done); end
  endtask
  task automatic test_snapshot();
    int first, bad;
    regs[3] = 32'hDEAD_BEEF;
    build_exp();
    collect(0, -1, 25, -1);
    n_cmp++; if (got.size() < 21 || {got[17], got[18], got[19], got[20]} !== 32'hDEAD_BEEF)
      begin n_err++; $display("FAIL snap_reg3 got=%h exp=deadbeef", got.size() >= 21 ? {got[17], got[18], got[19], got[20]} : 32'hx); end
    bad = seq_bad(first);
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL snap_seq got=%0d bad bytes exp=0 (first at %0d)", bad, first); end
    regs[3] = 32'h1000_0003;
    build_exp();
  endtask
  task automatic test_start_while_busy();
    int first, bad;
    collect(0, 40, -1, -1);
    n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL busy_done_count got=%0d exp=1", n_done); end
    n_cmp++; if (got.size() != 161) begin n_err++; $display("FAIL busy_len got=%0d exp=161", got.size()); end
    bad = seq_bad(first);
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL busy_seq got=%0d bad bytes exp=0 (first at %0d)", bad, first); end
  endtask
  task automatic test_reset_mid_frame();
    int first, bad, extra;
    collect(0, -1, -1, 100);
    n_cmp++; if (got.size() != 100) begin n_err++; $display("FAIL mid_reach100 got=%0d exp=100", got.size()); end
    tx_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got=%b exp=0", tx_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got=%b exp=0", busy); end
    n_cmp++; if (sel !== 5'd0) begin n_err++; $display("FAIL mid_sel got=%0d exp=0", sel); end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (done !== 1'b0 || tx_valid !== 1'b0) extra++;
      @(negedge clk);
    end
    n_cmp++; if (extra != 0) begin n_err++; $display("FAIL mid_no_done got=%0d active cycles exp=0", extra); end
    collect(0, -1, -1, -1);
    n_cmp++; if (got.size() != 161) begin n_err++; $display("FAIL mid_refr_len got=%0d exp=161", got.size()); end
    bad = seq_bad(first);
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL mid_refr_seq got=%0d bad bytes exp=0 (first at %0d)", bad, first); end
    n_cmp++; if (done_cyc != 226) begin n_err++; $display("FAIL mid_refr_done got=%0d exp=226", done_cyc); end
  endtask
  task automatic test_back_to_back();
    int d1 = 0, d2 = 0;
    logic v1 = 1'bx;
    logic v2 = 1'bx;
    logic [7:0] b2 = 'x;
    tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c < 1000; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (d1 == 0) d1 = c;
        else begin
          d2 = c;
          start = 1'b0;
          break;
        end
      end
      if (d1 != 0 && c == d1 + 1) v1 = tx_valid;
      if (d1 != 0 && c == d1 + 2) begin v2 = tx_valid; b2 = tx_data; end
    end
    start = 1'b0;
    n_cmp++; if (d1 != 226) begin n_err++; $display("FAIL b2b_done1 got=%0d exp=226", d1); end
    n_cmp++; if (v1 !== 1'b0) begin n_err++; $display("FAIL b2b_idle_gap got=%b exp=0", v1); end
    n_cmp++; if (v2 !== 1'b1 || b2 !== 8'hA5) begin n_err++; $display("FAIL b2b_sync got=%b/%h exp=1/a5", v2, b2); end
    n_cmp++; if (d2 != d1 + 227) begin n_err++; $display("FAIL b2b_done2 got=%0d exp=%0d", d2, d1 + 227); end
    repeat (3) @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_start_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
